multu_seq_unit: RTL and testbench

- Iterative unsigned multiplier owning the HI/LO register pair for the MIPS datapath.
- Executes MULTU; MFHI/MFLO read its hi_out/lo_out directly.
- Sits beside the EX stage: EX issues operands with a start pulse, and the pipeline stalls on busy.
- Radix-2 shift-add, one partial product per cycle, so the datapath needs no 64-bit combinational multiplier.

---
 rtl/multu_seq_if.sv | 35 +++
 rtl/multu_seq_unit.sv | 111 +++++++++++
 tb/tb_multu_seq_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/multu_seq_if.sv
// ----------------------------------------------------------------------------
// multu_seq_if
// Bundle between the EX stage and the sequential MULTU unit that owns HI/LO.
//   start   : EX -> unit, request a MULTU (sampled only when the unit is idle)
//   op_a    : EX -> unit, multiplicand (rs)
//   op_b    : EX -> unit, multiplier (rt)
//   busy    : unit -> EX, multiplication in progress (pipeline stall)
//   done    : unit -> EX, one-cycle pulse, fresh HI/LO this cycle
//   hi_out  : unit -> EX, HI register (upper half of last product)
//   lo_out  : unit -> EX, LO register (lower half of last product)
// master = EX side, slave = multiplier unit.
// ----------------------------------------------------------------------------
interface multu_seq_if #(
  parameter int unsigned WIDTH = 32
);

  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, op_a, op_b,
    input  busy, done, hi_out, lo_out
  );

  modport slave (
    input  start, op_a, op_b,
    output busy, done, hi_out, lo_out
  );

endinterface

// File: rtl/multu_seq_unit.sv
// ----------------------------------------------------------------------------
// multu_seq_unit
// Radix-2 shift-add unsigned multiplier holding the MIPS HI/LO pair.
// One partial product per cycle: WIDTH cycles of busy per MULTU, then a
// single done cycle in which the new HI/LO are visible.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset, overrides an in-flight operation
//   bus  : multu_seq_if.slave (start/op_a/op_b in, busy/done/hi_out/lo_out out)
// ----------------------------------------------------------------------------
module multu_seq_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  multu_seq_if.slave  bus
);

  localparam int unsigned CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PROD_W = 2 * WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [WIDTH-1:0]  mcand;
  logic [WIDTH-1:0]  mcand_nxt;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] prod_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [WIDTH-1:0]  hi_q;
  logic [WIDTH-1:0]  hi_nxt;
  logic [WIDTH-1:0]  lo_q;
  logic [WIDTH-1:0]  lo_nxt;
  logic              busy_q;
  logic              done_q;
  logic [WIDTH:0]    carry_sum;

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      prod   <= '0;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      mcand  <= mcand_nxt;
      prod   <= prod_nxt;
      cnt    <= cnt_nxt;
      hi_q   <= hi_nxt;
      lo_q   <= lo_nxt;
      // busy/done are decodes of the next state, registered alongside it
      busy_q <= (state_nxt == RUN);
      done_q <= (state_nxt == DONE);
    end
  end

  // Next-state and datapath step.
  always_comb begin
    state_nxt = state;
    mcand_nxt = mcand;
    prod_nxt  = prod;
    cnt_nxt   = cnt;
    hi_nxt    = hi_q;
    lo_nxt    = lo_q;

    // Extra top bit keeps the carry out of the partial-product add.
    carry_sum = {1'b0, prod[PROD_W-1:WIDTH]}
              + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});

    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          mcand_nxt = bus.op_a;
          prod_nxt  = {{WIDTH{1'b0}}, bus.op_b};
          cnt_nxt   = '0;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end

      RUN: begin
        // {carry_sum, P_lo} >> 1: the multiplier bits shift out at the bottom.
        prod_nxt = {carry_sum, prod[WIDTH-1:1]};
        cnt_nxt  = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          hi_nxt    = prod_nxt[PROD_W-1:WIDTH];
          lo_nxt    = prod_nxt[WIDTH-1:0];
          state_nxt = DONE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;

endmodule

// File: tb/tb_multu_seq_unit.sv
// ----------------------------------------------------------------------------
// tb_multu_seq_unit
// Self-checking bench for multu_seq_unit: a cycle-level behavioural model
// (64-bit product, busy countdown) is compared against the DUT every cycle,
// with directed literal checks on the key scenarios and a randomized run.
// ----------------------------------------------------------------------------
module tb_multu_seq_unit;

  localparam int unsigned WIDTH = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  multu_seq_if #(.WIDTH(WIDTH)) bus ();

  multu_seq_unit #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  // Behavioural model: product computed by plain multiplication.
  bit          m_busy;
  bit          m_done;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] m_prod;
  int          m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_hi   = '0;
      m_lo   = '0;
      m_cnt  = 0;
    end else if (m_busy) begin
      m_cnt++;
      if (m_cnt == WIDTH) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        {m_hi, m_lo} = m_prod;
      end
    end else begin
      m_done = 1'b0;
      if (bus.start) begin
        m_busy = 1'b1;
        m_cnt  = 0;
        m_prod = 64'(bus.op_a) * 64'(bus.op_b);
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      n_vec++;
      if (bus.busy !== m_busy || bus.done !== m_done ||
          bus.hi_out !== m_hi || bus.lo_out !== m_lo) begin
        n_err++;
        $display("FAIL cycle_cmp t=%0t: dut busy=%0b done=%0b hi=%h lo=%h, model busy=%0b done=%0b hi=%h lo=%h",
                 $time, bus.busy, bus.done, bus.hi_out, bus.lo_out,
                 m_busy, m_done, m_hi, m_lo);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op_a  = $urandom;
    bus.op_b  = $urandom;
  endtask

  // Returns at the negedge where done is seen. noise: 0 none,
  // 1 random start/operands during RUN, 2 operands only (start untouched).
  task automatic wait_done(input int noise, output int busy_cyc);
    int  cyc;
    bit  fin;
    cyc      = 0;
    busy_cyc = 0;
    fin      = 1'b0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (bus.busy === 1'b1) busy_cyc++;
      if (bus.done === 1'b1) begin
        fin = 1'b1;
        if (noise == 1) bus.start = 1'b0;
      end else if (cyc >= 100) begin
        n_vec++;
        n_err++;
        $display("FAIL done_timeout: no done after %0d cycles", cyc);
        fin = 1'b1;
      end else if (noise == 1) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.op_a  = $urandom;
        bus.op_b  = $urandom;
      end else if (noise == 2) begin
        bus.op_a  = $urandom;
        bus.op_b  = $urandom;
      end
    end
  endtask

  initial begin
    int bc;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    check_en = 1'b1;

    // Reset state
    @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_hilo", {bus.hi_out, bus.lo_out}, 64'd0);

    // 3 x 5
    issue(32'd3, 32'd5);
    wait_done(0, bc);
    chk("3x5_busy_len", 64'(bc), 64'd32);
    chk("3x5_hilo", {bus.hi_out, bus.lo_out}, 64'h00000000_0000000F);
    @(negedge clk);
    chk("3x5_after_busy", 64'(bus.busy), 64'd0);
    chk("3x5_after_done", 64'(bus.done), 64'd0);

    // All-ones: carry out of the add
    issue(32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(0, bc);
    chk("ones_hilo", {bus.hi_out, bus.lo_out}, 64'hFFFFFFFE_00000001);

    // start held through RUN with changing operands
    issue(32'h00010000, 32'h00010000);
    bus.start = 1'b1;
    bus.op_a  = 32'd7;
    bus.op_b  = 32'd7;
    wait_done(2, bc);
    chk("hold_busy_len", 64'(bc), 64'd32);
    chk("hold_hilo", {bus.hi_out, bus.lo_out}, 64'h00000001_00000000);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("hold_restart_busy", 64'(bus.busy), 64'd1);
    wait_done(0, bc);

    // Back-to-back: start in the DONE cycle
    issue(32'd6, 32'd7);
    wait_done(0, bc);
    chk("b2b_first_hilo", {bus.hi_out, bus.lo_out}, 64'd42);
    bus.start = 1'b1;
    bus.op_a  = 32'h12345678;
    bus.op_b  = 32'h00000010;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op_a  = $urandom;
    bus.op_b  = $urandom;
    @(negedge clk);
    chk("b2b_busy_again", 64'(bus.busy), 64'd1);
    chk("b2b_hold_hilo", {bus.hi_out, bus.lo_out}, 64'd42);
    wait_done(0, bc);
    chk("b2b_second_hilo", {bus.hi_out, bus.lo_out}, 64'h00000001_23456780);

    // Reset mid-operation
    issue(32'h80000000, 32'd2);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 64'(bus.busy), 64'd0);
    chk("rst_mid_done", 64'(bus.done), 64'd0);
    chk("rst_mid_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
    issue(32'd2, 32'd2);
    wait_done(0, bc);
    chk("post_rst_hilo", {bus.hi_out, bus.lo_out}, 64'd4);

    // Zero operand still runs full length
    issue(32'd0, 32'hDEADBEEF);
    wait_done(0, bc);
    chk("zero_busy_len", 64'(bc), 64'd32);
    chk("zero_hilo", {bus.hi_out, bus.lo_out}, 64'd0);

    // Randomized operations with start noise during RUN
    repeat (40) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      issue($urandom, $urandom);
      wait_done(1, bc);
      chk("rand_busy_len", 64'(bc), 64'd32);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
